// File: rtl/accumulator_pkg.sv
// Shared opcodes, FSM encoding and width helper for the accumulator bank.
package accumulator_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_MAC  = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWb   = 2'd2
  } bank_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Serial unsigned shift-add multiplier: one multiplier bit per cycle, Width cycles per product.
module shift_add_mul
  import accumulator_pkg::*;
#(
  parameter int unsigned Width = 16,
  localparam int unsigned CntW = (clog2(Width) > 1) ? clog2(Width) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [Width-1:0]   mcand_i,
  input  logic [Width-1:0]   mplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  logic [2*Width-1:0] prod_q, prod_d;
  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last_bit;

  assign last_bit = (cnt_q == CntW'(Width - 1));

  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      prod_d   = '0;
      mcand_d  = {{Width{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (last_bit) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // High during the final bit cycle; the product is complete the cycle after.
  assign done_o    = busy_q && last_bit;
  assign busy_o    = busy_q;
  assign product_o = prod_q;

endmodule

// File: rtl/accumulator_bank.sv
// NUM_CH unsigned accumulators behind one command port, with a serial multiply-accumulate op.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SATURATE   = 0,
  localparam int unsigned CH_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mult,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]     z,
  output logic [NUM_CH-1:0]     ovf,
  output logic                  done
);

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam logic        Sat = (SATURATE != 0);

  bank_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q, ovf_d;
  logic [CH_W-1:0]       mac_ch_q, mac_ch_d;

  logic                  accept;
  logic                  mul_start, mul_busy, mul_done;
  logic [PW-1:0]         mul_product;
  logic                  is_sub;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   ext;
  logic                  wb_high_nz;

  assign cmd_ready  = !rst && (state_q == StIdle) && !mul_busy;
  assign accept     = cmd_valid && cmd_ready;
  assign mul_start  = accept && (cmd_op == OP_MAC);
  assign wb_high_nz = |mul_product[PW-1:DATA_WIDTH];

  shift_add_mul #(
    .Width(DATA_WIDTH)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (mul_start),
    .mcand_i  (cmd_data),
    .mplier_i (cmd_mult),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // INC/DEC reuse the ADD/SUB path with an operand of one.
  always_comb begin
    operand = cmd_data;
    is_sub  = 1'b0;
    case (cmd_op)
      OP_INC: operand = DATA_WIDTH'(1);
      OP_DEC: begin
        operand = DATA_WIDTH'(1);
        is_sub  = 1'b1;
      end
      OP_SUB: is_sub = 1'b1;
      default: ;
    endcase
  end

  // Channel match by equality so an out-of-range index hits nothing.
  always_comb begin
    state_d  = state_q;
    mac_ch_d = mac_ch_q;
    ovf_d    = ovf_q;
    ext      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_d[i] = acc_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_op == OP_MAC) begin
            state_d  = StRun;
            mac_ch_d = cmd_ch;
          end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (cmd_ch == CH_W'(i)) begin
                case (cmd_op)
                  OP_LOAD: begin
                    acc_d[i] = cmd_data;
                    ovf_d[i] = 1'b0;
                  end
                  OP_CLR: begin
                    acc_d[i] = '0;
                    ovf_d[i] = 1'b0;
                  end
                  OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
                    ext = is_sub ? ({1'b0, acc_q[i]} - {1'b0, operand})
                                 : ({1'b0, acc_q[i]} + {1'b0, operand});
                    acc_d[i] = ext[DATA_WIDTH-1:0];
                    if (ext[DATA_WIDTH]) begin
                      ovf_d[i] = 1'b1;
                      if (Sat) acc_d[i] = is_sub ? '0 : '1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end
      end
      StRun: begin
        if (mul_done) state_d = StWb;
      end
      StWb: begin
        state_d = StIdle;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (mac_ch_q == CH_W'(i)) begin
            ext      = {1'b0, acc_q[i]} + {1'b0, mul_product[DATA_WIDTH-1:0]};
            acc_d[i] = ext[DATA_WIDTH-1:0];
            if (ext[DATA_WIDTH] || wb_high_nz) begin
              ovf_d[i] = 1'b1;
              if (Sat) acc_d[i] = '1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mac_ch_q <= '0;
      ovf_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      mac_ch_q <= mac_ch_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    z       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      z[i] = (acc_q[i] == '0);
      if (rd_ch == CH_W'(i)) rd_data = acc_q[i];
    end
  end

  assign ovf  = ovf_q;
  assign done = (state_q == StWb);

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench: a wrapping and a saturating bank driven in lockstep from the same commands.
module tb_accumulator_bank;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLR = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC = 3'd4, ADD = 3'd5, SUB = 3'd6, MAC = 3'd7;

  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [1:0]  cmd_ch = 2'd0, rd_ch = 2'd0;
  logic [15:0] cmd_data = 16'd0, cmd_mult = 16'd0;
  logic        cmd_ready, cmd_ready_s, done, done_s;
  logic [15:0] rd_data, rd_data_s;
  logic [3:0]  z, z_s, ovf, ovf_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  accumulator_bank #(.DATA_WIDTH(16), .NUM_CH(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_mult(cmd_mult), .rd_ch(rd_ch),
    .rd_data(rd_data), .z(z), .ovf(ovf), .done(done)
  );

  accumulator_bank #(.DATA_WIDTH(16), .NUM_CH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_mult(cmd_mult), .rd_ch(rd_ch),
    .rd_data(rd_data_s), .z(z_s), .ovf(ovf_s), .done(done_s)
  );

  task automatic drive(input logic [2:0] op, input logic [1:0] ch, input logic [15:0] d,
                       input logic [15:0] m);
    cmd_op = op; cmd_ch = ch; cmd_data = d; cmd_mult = m; cmd_valid = 1'b1;
  endtask

  // One accepted command: valid for exactly one rising edge, returns on the following negedge.
  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [15:0] d,
                       input logic [15:0] m);
    @(negedge clk);
    drive(op, ch, d, m);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    total++; if (z !== 4'b1111 || z_s !== 4'b1111) begin bad++; $display("FAIL rst_z: got %b/%b want 1111", z, z_s); end
    total++; if (ovf !== 4'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_ovf_done: got %b/%b want 0000/0", ovf, done); end
    total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL rst_rd: got %h want 0000", rd_data); end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_load;
    issue(LOAD, 2'd2, 16'h1234, 16'h0);
    rd_ch = 2'd2; #1;
    total++; if (rd_data !== 16'h1234) begin bad++; $display("FAIL load_rd: got %h want 1234", rd_data); end
    total++; if (z !== 4'b1011) begin bad++; $display("FAIL load_z: got %b want 1011", z); end
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL load_ovf: got %b want 0000", ovf); end
  endtask

  task automatic test_inc_overflow;
    issue(LOAD, 2'd0, 16'hFFFF, 16'h0);
    issue(INC, 2'd0, 16'h0, 16'h0);
    rd_ch = 2'd0; #1;
    total++; if (rd_data !== 16'h0000 || z !== 4'b1011) begin bad++; $display("FAIL inc_wrap: got %h z=%b want 0000 z=1011", rd_data, z); end
    total++; if (rd_data_s !== 16'hFFFF || z_s !== 4'b1010) begin bad++; $display("FAIL inc_sat: got %h z=%b want ffff z=1010", rd_data_s, z_s); end
    total++; if (ovf !== 4'b0001 || ovf_s !== 4'b0001) begin bad++; $display("FAIL inc_ovf: got %b/%b want 0001", ovf, ovf_s); end
    issue(CLR, 2'd0, 16'h0, 16'h0);
    #1;
    total++; if (ovf !== 4'b0000 || ovf_s !== 4'b0000) begin bad++; $display("FAIL clr_ovf: got %b/%b want 0000", ovf, ovf_s); end
    total++; if (rd_data_s !== 16'h0000) begin bad++; $display("FAIL clr_rd: got %h want 0000", rd_data_s); end
  endtask

  task automatic test_sub_borrow;
    issue(LOAD, 2'd1, 16'd5, 16'h0);
    issue(SUB, 2'd1, 16'd7, 16'h0);
    rd_ch = 2'd1; #1;
    total++; if (rd_data !== 16'hFFFE) begin bad++; $display("FAIL sub_wrap: got %h want fffe", rd_data); end
    total++; if (rd_data_s !== 16'h0000) begin bad++; $display("FAIL sub_sat: got %h want 0000", rd_data_s); end
    total++; if (ovf !== 4'b0010 || ovf_s !== 4'b0010) begin bad++; $display("FAIL sub_ovf: got %b/%b want 0010", ovf, ovf_s); end
    issue(LOAD, 2'd1, 16'd5, 16'h0);
    issue(DEC, 2'd1, 16'h0, 16'h0);
    issue(ADD, 2'd1, 16'h0010, 16'h0);
    issue(NOP, 2'd1, 16'hAAAA, 16'h0);
    #1;
    total++; if (rd_data !== 16'h0014 || rd_data_s !== 16'h0014) begin bad++; $display("FAIL dec_add: got %h/%h want 0014", rd_data, rd_data_s); end
    total++; if (ovf !== 4'b0000 || ovf_s !== 4'b0000) begin bad++; $display("FAIL dec_add_ovf: got %b/%b want 0000", ovf, ovf_s); end
  endtask

  task automatic test_mac;
    int low_cnt, done_cnt, done_at;
    logic [15:0] exp_rd [3];
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0014; exp_rd[2] = 16'h1234;
    issue(LOAD, 2'd3, 16'd10, 16'h0);
    @(negedge clk);
    drive(MAC, 2'd3, 16'd300, 16'd200);
    @(negedge clk);
    cmd_valid = 1'b0;
    low_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      if (!cmd_ready) low_cnt++;
      if (done) begin done_cnt++; done_at = k; end
    end
    @(negedge clk);
    total++; if (low_cnt != 17) begin bad++; $display("FAIL mac_busy_cycles: got %0d want 17", low_cnt); end
    total++; if (done_cnt != 1 || done_at != 17) begin bad++; $display("FAIL mac_done_pulse: got %0d at %0d want 1 at 17", done_cnt, done_at); end
    total++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mac_after: ready=%b done=%b want 1/0", cmd_ready, done); end
    rd_ch = 2'd3; #1;
    total++; if (rd_data !== 16'd60010 || rd_data_s !== 16'd60010) begin bad++; $display("FAIL mac_result: got %0d/%0d want 60010", rd_data, rd_data_s); end
    total++; if (ovf !== 4'b0000 || ovf_s !== 4'b0000) begin bad++; $display("FAIL mac_ovf: got %b/%b want 0000", ovf, ovf_s); end
    for (int c = 0; c < 3; c++) begin
      rd_ch = 2'(c); #1;
      total++; if (rd_data !== exp_rd[c]) begin bad++; $display("FAIL mac_other_ch%0d: got %h want %h", c, rd_data, exp_rd[c]); end
    end
  endtask

  task automatic test_mac_overflow;
    bit seen;
    @(negedge clk);
    drive(MAC, 2'd1, 16'h0100, 16'h0100);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL mac_ovf_done: got no done want pulse"); end
    @(negedge clk);
    rd_ch = 2'd1; #1;
    total++; if (rd_data !== 16'h0014) begin bad++; $display("FAIL mac_ovf_wrap: got %h want 0014", rd_data); end
    total++; if (rd_data_s !== 16'hFFFF) begin bad++; $display("FAIL mac_ovf_sat: got %h want ffff", rd_data_s); end
    total++; if (ovf !== 4'b0010 || ovf_s !== 4'b0010) begin bad++; $display("FAIL mac_ovf_flag: got %b/%b want 0010", ovf, ovf_s); end
    // Multiplier of zero still pulses done and leaves the flags alone.
    @(negedge clk);
    drive(MAC, 2'd0, 16'h1234, 16'h0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL mac_zero_done: got no done want pulse"); end
    @(negedge clk);
    rd_ch = 2'd0; #1;
    total++; if (rd_data !== 16'h0000 || ovf !== 4'b0010) begin bad++; $display("FAIL mac_zero: got %h ovf=%b want 0000 ovf=0010", rd_data, ovf); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(LOAD, 2'd3, 16'h0010, 16'h0);
    @(negedge clk);
    drive(ADD, 2'd3, 16'h0005, 16'h0);
    @(negedge clk);
    drive(DEC, 2'd3, 16'h0, 16'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rd_ch = 2'd3; #1;
    total++; if (rd_data !== 16'h0014 || rd_data_s !== 16'h0014) begin bad++; $display("FAIL b2b: got %h/%h want 0014", rd_data, rd_data_s); end
  endtask

  task automatic test_held_and_abort;
    int busy;
    int done_cnt;
    // Command held valid while a MAC is busy must wait for ready.
    @(negedge clk);
    drive(MAC, 2'd0, 16'd2, 16'd3);
    @(negedge clk);
    drive(LOAD, 2'd0, 16'h0050, 16'h0);
    busy = 0;
    while (!cmd_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    total++; if (busy != 17) begin bad++; $display("FAIL held_busy: got %0d want 17", busy); end
    rd_ch = 2'd0; #1;
    total++; if (rd_data !== 16'd6) begin bad++; $display("FAIL held_mac_first: got %h want 0006", rd_data); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    total++; if (rd_data !== 16'h0050 || rd_data_s !== 16'h0050) begin bad++; $display("FAIL held_load: got %h/%h want 0050", rd_data, rd_data_s); end
    // Reset in the middle of a MAC aborts it without writeback.
    issue(LOAD, 2'd2, 16'd7, 16'h0);
    rd_ch = 2'd2; #1;
    total++; if (rd_data !== 16'd7) begin bad++; $display("FAIL abort_pre: got %h want 0007", rd_data); end
    issue(MAC, 2'd2, 16'd3, 16'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive(LOAD, 2'd2, 16'h0099, 16'h0);
    @(negedge clk);
    total++; if (rd_data !== 16'h0 || z !== 4'b1111) begin bad++; $display("FAIL abort_rst: got %h z=%b want 0000 z=1111", rd_data, z); end
    total++; if (cmd_ready !== 1'b0 || done !== 1'b0 || ovf !== 4'b0) begin bad++; $display("FAIL abort_rst_ctl: got ready=%b done=%b ovf=%b want 0/0/0000", cmd_ready, done, ovf); end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || done_s) done_cnt++;
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
    total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL abort_no_wb: got %h want 0000", rd_data); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc_overflow();
    test_sub_borrow();
    test_mac();
    test_mac_overflow();
    test_back_to_back();
    test_held_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1);
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Multi-channel successor to the single accumulator register: NUM_CH independent DATA_WIDTH-bit unsigned accumulators behind one command port.
- Supported ops: load, clear, inc, dec, add, sub, and a multi-cycle shift-add multiply-accumulate (MAC).
- Provides per-channel zero and sticky-overflow flags, plus optional saturation.
- Sits between the core controller and the multiplier datapath as the partial-sum store for each core.

Parameters:
DATA_WIDTH, 16, width of each accumulator and of the command operands
NUM_CH, 4, number of accumulator channels (>=1)
SATURATE, 0, 0 = wrap on overflow/underflow; 1 = clamp to all-ones / zero
(local) CH_W = max(1, clog2(NUM_CH)), channel index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  bank can accept a command this cycle
cmd_op  in  3  opcode (see Behaviour)
cmd_ch  in  CH_W  target channel
cmd_data  in  DATA_WIDTH  operand (LOAD/ADD/SUB value, MAC multiplicand)
cmd_mult  in  DATA_WIDTH  MAC multiplier; ignored by other ops
rd_ch  in  CH_W  read channel select
rd_data  out  DATA_WIDTH  acc[rd_ch], combinational from register; 0 if rd_ch >= NUM_CH
z  out  NUM_CH  z[i] = (acc[i] == 0), combinational from register
ovf  out  NUM_CH  sticky overflow/underflow flag per channel
done  out  1  one-cycle pulse on MAC writeback

Behaviour:
- Reset (synchronous rst=1):
  - acc[*]=0, ovf=0, z=all ones, done=0, FSM=IDLE, cmd_ready=0 while rst=1.
  - rst asserted mid-MAC aborts the MAC with no writeback.
  - rst has priority over every other input.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = !rst && state==IDLE. Inputs are ignored when not accepted.
- Opcodes: 0 NOP, 1 LOAD, 2 CLR, 3 INC, 4 DEC, 5 ADD, 6 SUB, 7 MAC.
- Single-cycle ops (1-6):
  - The result is written at the accept edge and is visible on rd_data/z in the next cycle.
  - Unlike the previous block, z has no extra cycle of lag.
  - Back-to-back acceptance is allowed every cycle.
- Arithmetic (unsigned, DATA_WIDTH+1 internal):
  - INC/ADD: on carry out, set ovf[ch]. Result wraps (SATURATE=0) or becomes all ones (SATURATE=1).
  - DEC/SUB: on borrow, set ovf[ch]. Result wraps or becomes 0.
  - LOAD and CLR write cmd_data and 0 respectively, and clear ovf[ch].
  - ovf[ch] otherwise holds once set.
- MAC FSM (states IDLE -> RUN -> WB -> IDLE):
  - Accept: latch ch, multiplicand, multiplier; clear the 2*DATA_WIDTH product register and the bit counter; go to RUN.
  - RUN: DATA_WIDTH cycles. Each cycle, if the current multiplier LSB is 1, add the shifted multiplicand to the product; then shift. After the last bit, go to WB.
  - WB (1 cycle):
    - acc[ch] += low DATA_WIDTH bits of the product.
    - Overflow condition: the high product half is nonzero or the sum carries. On overflow, set ovf[ch] and wrap or clamp per SATURATE.
    - done=1 for this cycle; return to IDLE.
  - Latency: accept at edge 0, result written at edge DATA_WIDTH+1, cmd_ready high again the cycle after WB.
  - Other channels are never modified during a MAC.
- Multiplier of 0: still takes the full DATA_WIDTH cycles. Writeback adds 0 with no ovf change.
- Out of range: cmd_ch >= NUM_CH means the command is accepted with no state change. A MAC still runs its cycles and pulses done, but writes nothing.
- NOP: accepted, no effect.

Decomposition:
- Package accumulator_pkg: opcode constants (OP_NOP..OP_MAC), FSM state encoding, and a clog2 helper function.
- One natural sub-module, shift_add_mul: DATA_WIDTH-cycle serial unsigned multiplier with start/busy/done and a 2*DATA_WIDTH product. It is instantiated once; the bank owns the channel registers, flags and handshake.

Test Plan (DATA_WIDTH=16, NUM_CH=4):
1. Reset, then LOAD ch2 0x1234, then read ch2 -> rd_data=0x1234 next cycle; z=4'b1011; ovf=0.
2. LOAD ch0 0xFFFF, then INC ch0 -> SATURATE=0: acc=0x0000, z[0]=1, ovf[0]=1. SATURATE=1: acc=0xFFFF, ovf[0]=1. A following CLR ch0 clears ovf[0].
3. LOAD ch1 5, then SUB ch1 7 -> wrap: 0xFFFE with ovf[1]=1. Saturate: 0x0000 with ovf[1]=1.
4. LOAD ch3 10, then MAC ch3 data=300 mult=200 ->
   - cmd_ready is low for 17 cycles.
   - done pulses at edge 17.
   - acc[3] = (10 + 60000) mod 65536 = 60010, ovf[3]=0.
   - ch0-2 are unchanged.
5. MAC ch1 0x0100 x 0x0100 -> product 0x10000; acc[1] += 0; ovf[1]=1.
6. Assert rst during RUN of a MAC on ch2 (acc=7) -> acc[2]=0, no done pulse, cmd_ready=1 the cycle after rst deasserts. Also check that a command with cmd_valid held while busy is accepted only once ready returns.
